apb_req_arbiter: RTL and testbench

- Shares one APB_Master "previous system" port (PSI_ADDR/PSI_WRITE/PSI_WDATA/Transfer) between NO_REQ independent requesters.
- Arbitrates round-robin, issues one transfer at a time, and monitors the APB bus for completion.
- Returns read data and error status to the granted requester.
- Sits between the requesters and the master; the APB bus itself is only observed.

---
 rtl/apb_arb_pkg.sv | 37 +++
 rtl/apb_req_arbiter_rr.sv | 40 ++++
 rtl/apb_req_arbiter.sv | 132 +++++++++++++
 tb/tb_apb_req_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB request arbiter.
// ARB_FIXED_PRIO_EN selects lowest-index-wins instead of round-robin.
package apb_arb_pkg;

  localparam int DEF_NO_REQ = 4;
  localparam int MAX_REQ    = 8;

  typedef enum logic [3:0] {
    ARB_IDLE = 4'b0001,
    ISSUE    = 4'b0010,
    WAIT     = 4'b0100,
    RESP     = 4'b1000
  } arb_state_e;

  // First set bit of req, searching upward from ptr+1 and wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_onehot(
    input logic [MAX_REQ-1:0] req,
    input logic [2:0]         ptr,
    input logic [3:0]         n
  );
    logic [MAX_REQ-1:0] g;
    logic [3:0]         pos;
    logic               found;
    g     = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      pos = {1'b0, ptr} + 4'(k);
      if (pos >= n) pos = pos - n;
      if ((k <= int'(n)) && !found && req[pos[2:0]]) begin
        g[pos[2:0]] = 1'b1;
        found       = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/apb_req_arbiter_rr.sv
// Combinational winner selection for the APB request arbiter.
// ARB_FIXED_PRIO_EN turns it into a fixed lowest-index priority encoder.
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NO_REQ = DEF_NO_REQ,
  parameter int REQ_W  = $clog2(NO_REQ)
) (
  input  logic [NO_REQ-1:0] req,
  input  logic [REQ_W-1:0]  ptr,
  output logic [NO_REQ-1:0] gnt,
  output logic [REQ_W-1:0]  idx,
  output logic              any
);

  logic [MAX_REQ-1:0] req_x;
  logic [MAX_REQ-1:0] gnt_x;
  logic               unused_ok;

  assign req_x = MAX_REQ'(req);

`ifdef ARB_FIXED_PRIO_EN
  assign gnt_x     = req_x & (~req_x + MAX_REQ'(1));
  assign unused_ok = ^{ptr, gnt_x};
`else
  assign gnt_x     = rr_onehot(req_x, 3'(ptr), 4'(NO_REQ));
  assign unused_ok = ^gnt_x;
`endif

  assign gnt = gnt_x[NO_REQ-1:0];
  assign any = |req;

  always_comb begin
    idx = '0;
    for (int i = 0; i < NO_REQ; i++) begin
      if (gnt[i]) idx = REQ_W'(i);
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master request port between NO_REQ requesters.
// Define ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NO_SLAVES  = 4,
  parameter int NO_REQ     = DEF_NO_REQ,
  parameter int REQ_W      = $clog2(NO_REQ)
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  input  logic [NO_REQ-1:0]            req_valid,
  input  logic [NO_REQ-1:0]            req_write,
  input  logic [NO_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NO_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NO_REQ-1:0]            req_gnt,
  output logic [NO_REQ-1:0]            req_done,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic                         rsp_slverr,
  output logic [ADDR_WIDTH-1:0]        PSI_ADDR,
  output logic                         PSI_WRITE,
  output logic [DATA_WIDTH-1:0]        PSI_WDATA,
  output logic                         Transfer,
  input  logic [NO_SLAVES-1:0]         PSELx,
  input  logic                         PENABLE,
  input  logic                         PREADY,
  input  logic [DATA_WIDTH-1:0]        PRDATA,
  input  logic                         PSLVERR
);

  arb_state_e            state;
  arb_state_e            state_nxt;
  logic [NO_REQ-1:0]     win_gnt;
  logic [REQ_W-1:0]      win_idx;
  logic [REQ_W-1:0]      ptr;
  logic                  win_any;
  logic                  complete;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic                  win_write;

  rr_arbiter #(
    .NO_REQ (NO_REQ),
    .REQ_W  (REQ_W)
  ) u_rr (
    .req (req_valid),
    .ptr (ptr),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_write = 1'b0;
    for (int i = 0; i < NO_REQ; i++) begin
      if (win_gnt[i]) begin
        win_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        win_write = req_write[i];
      end
    end
  end

  // The bus is only watched; completion is the ACCESS phase ending.
  assign complete = PENABLE & (|PSELx) & (PREADY | PSLVERR);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= ARB_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == ARB_IDLE): if (win_any) state_nxt = ISSUE;
      (state == ISSUE):    state_nxt = WAIT;
      (state == WAIT):     if (complete) state_nxt = RESP;
      (state == RESP):     state_nxt = ARB_IDLE;
      default:             state_nxt = ARB_IDLE;
    endcase
  end

  // PSI_* stay put until the next grant; the master re-reads them in ACCESS.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      req_gnt    <= '0;
      req_done   <= '0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
      PSI_ADDR   <= '0;
      PSI_WRITE  <= 1'b0;
      PSI_WDATA  <= '0;
      Transfer   <= 1'b0;
      ptr        <= REQ_W'(NO_REQ - 1);
    end else begin
      unique case (1'b1)
        (state == ARB_IDLE): begin
          if (win_any) begin
            PSI_ADDR  <= win_addr;
            PSI_WRITE <= win_write;
            PSI_WDATA <= win_wdata;
            Transfer  <= 1'b1;
            req_gnt   <= win_gnt;
            ptr       <= win_idx;
          end
        end
        (state == ISSUE): begin
          Transfer <= 1'b0;
        end
        (state == WAIT): begin
          if (complete) begin
            req_done   <= req_gnt;
            rsp_slverr <= PSLVERR;
            if (!PSI_WRITE) rsp_rdata <= PRDATA;
          end
        end
        (state == RESP): begin
          req_done <= '0;
          req_gnt  <= '0;
        end
        default: begin
          Transfer <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed scenarios plus random traffic
// against a transaction-level model of the arbitration rules.
module tb_apb_req_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NS = 4;
  localparam int NR = 4;
  localparam int RW = 2;

  logic             PCLK;
  logic             PRESETn;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    req_gnt;
  logic [NR-1:0]    req_done;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_slverr;
  logic [AW-1:0]    PSI_ADDR;
  logic             PSI_WRITE;
  logic [DW-1:0]    PSI_WDATA;
  logic             Transfer;
  logic [NS-1:0]    PSELx;
  logic             PENABLE;
  logic             PREADY;
  logic [DW-1:0]    PRDATA;
  logic             PSLVERR;

  apb_req_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NO_SLAVES  (NS),
    .NO_REQ     (NR),
    .REQ_W      (RW)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_gnt    (req_gnt),
    .req_done   (req_done),
    .rsp_rdata  (rsp_rdata),
    .rsp_slverr (rsp_slverr),
    .PSI_ADDR   (PSI_ADDR),
    .PSI_WRITE  (PSI_WRITE),
    .PSI_WDATA  (PSI_WDATA),
    .Transfer   (Transfer),
    .PSELx      (PSELx),
    .PENABLE    (PENABLE),
    .PREADY     (PREADY),
    .PRDATA     (PRDATA),
    .PSLVERR    (PSLVERR)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  initial forever @(posedge PCLK) cyc++;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  function automatic int oh2i(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Slave/master bus stand-in, driven on the falling edge
  bit          rand_bus  = 0;
  int          cfg_wait  = 0;
  bit          cfg_err   = 0;
  logic [31:0] cfg_rdata = '0;
  int          bst = 0;
  int          wcnt = 0;
  bit          prev_tr = 0;
  bit          fin = 0;
  bit          b_err = 0;
  bit          b_enr = 0;
  logic [31:0] b_rd = '0;

  initial begin
    PSELx = '0; PENABLE = 0; PREADY = 0; PSLVERR = 0; PRDATA = '0;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        bst = 0; prev_tr = 0; fin = 0;
      end else begin
        case (bst)
          0: if (prev_tr) bst = 1;
          1: begin
            bst = 2;
            if (rand_bus) begin
              wcnt  = $urandom_range(0, 3);
              b_err = ($urandom_range(0, 4) == 0);
              b_enr = $urandom_range(0, 1);
              b_rd  = $urandom;
            end else begin
              wcnt = cfg_wait; b_err = cfg_err; b_enr = 0; b_rd = cfg_rdata;
            end
          end
          default: begin
            if (fin) bst = prev_tr ? 1 : 0;
            else     wcnt--;
          end
        endcase
      end
      PSELx   = (bst != 0) ? (4'b0001 << PSI_ADDR[31:30]) : 4'b0000;
      PENABLE = (bst == 2);
      fin     = (bst == 2) && (wcnt == 0);
      PREADY  = fin && !(b_err && b_enr);
      PSLVERR = fin && b_err;
      PRDATA  = fin ? b_rd : $urandom;
      prev_tr = Transfer;
    end
  end

  // Transaction-level model of the arbiter
  bit          m_busy = 0;
  bit          m_dnow = 0;
  int          m_w    = 0;
  int          m_age  = 0;
  int          m_ptr  = NR - 1;
  logic [31:0] m_addr = '0;
  logic        m_wr   = 0;
  logic [31:0] m_wd   = '0;
  logic [31:0] m_rdata = '0;
  logic        m_err  = 0;

  function automatic int pick(input logic [NR-1:0] v, input int p);
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < NR; i++) if (v[i] && p >= 0) return i;
`else
    for (int k = 1; k <= NR; k++) if (v[(p + k) % NR]) return (p + k) % NR;
`endif
    return -1;
  endfunction

  initial forever @(posedge PCLK) begin
    if (!PRESETn) begin
      m_busy = 0; m_dnow = 0; m_ptr = NR - 1; m_rdata = '0; m_err = 0;
    end else if (m_busy) begin
      if (m_dnow) begin
        m_busy = 0; m_dnow = 0;
      end else begin
        if (m_age >= 1 && PENABLE && (|PSELx) && (PREADY || PSLVERR)) begin
          m_dnow = 1;
          m_err  = PSLVERR;
          if (!m_wr) m_rdata = PRDATA;
        end
        m_age++;
      end
    end else if (|req_valid) begin
      m_w    = pick(req_valid, m_ptr);
      m_ptr  = m_w;
      m_busy = 1;
      m_age  = 0;
      m_addr = req_addr[m_w*AW +: AW];
      m_wr   = req_write[m_w];
      m_wd   = req_wdata[m_w*DW +: DW];
    end
  end

  bit            chk_en = 0;
  logic [NR-1:0] eg;
  logic [NR-1:0] ed;

  initial forever @(negedge PCLK) begin
    if (chk_en) begin
      eg = m_busy ? (4'b0001 << m_w) : 4'b0000;
      ed = m_dnow ? eg : 4'b0000;
      chk("gnt", req_gnt, eg);
      chk("done", req_done, ed);
      chk("transfer", Transfer, (m_busy && m_age == 0));
      chk("rdata", rsp_rdata, m_rdata);
      if (m_busy) begin
        chk("psi_addr", PSI_ADDR, m_addr);
        chk("psi_write", PSI_WRITE, m_wr);
        chk("psi_wdata", PSI_WDATA, m_wd);
      end
      if (m_dnow) chk("slverr", rsp_slverr, m_err);
    end
  end

  int tr_cnt = 0;
  int done_cnt = 0;
  int gq[$];
  int dq[$];

  initial forever @(negedge PCLK) begin
    if (Transfer) begin tr_cnt++; gq.push_back(oh2i(req_gnt)); end
    if (|req_done) begin done_cnt++; dq.push_back(oh2i(req_done)); end
  end

  task automatic set_req(input int i, input bit v, input bit w,
                         input logic [31:0] a, input logic [31:0] d);
    req_valid[i] = v;
    req_write[i] = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic wait_tr(input int maxc, output int idx);
    idx = -1;
    for (int k = 0; k < maxc && idx < 0; k++) begin
      @(negedge PCLK);
      if (Transfer) idx = oh2i(req_gnt);
    end
    if (idx < 0) chk("timeout_transfer", 0, 1);
  endtask

  task automatic wait_done(input int i, input int maxc, output bit ok);
    ok = 0;
    for (int k = 0; k < maxc && !ok; k++) begin
      @(negedge PCLK);
      if (req_done[i]) ok = 1;
    end
    if (!ok) chk("timeout_done", 0, 1);
  endtask

  task automatic pulse_reset();
    @(negedge PCLK);
    #2 PRESETn = 0;
    repeat (2) @(negedge PCLK);
    #2 PRESETn = 1;
  endtask

  int t0c, d0, t_tr, idx, n, exp_g;
  bit ok;

  initial begin
    PRESETn = 0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge PCLK);
    chk("rst_gnt", req_gnt, 0);
    chk("rst_done", req_done, 0);
    chk("rst_transfer", Transfer, 0);
    chk("rst_psi_addr", PSI_ADDR, 0);
    chk("rst_psi_write", PSI_WRITE, 0);
    chk("rst_psi_wdata", PSI_WDATA, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_slverr", rsp_slverr, 0);
    #2 PRESETn = 1;
    chk_en = 1;

    // Single zero-wait read
    @(negedge PCLK);
    cfg_wait = 0; cfg_err = 0; cfg_rdata = 32'hDEAD_BEEF;
    t0c = tr_cnt; d0 = done_cnt;
    set_req(0, 1, 0, 32'h4000_0010, 32'h0);
    wait_tr(20, idx);
    t_tr = cyc;
    chk("t1_grant", idx, 0);
    chk("t1_psi_addr", PSI_ADDR, 32'h4000_0010);
    chk("t1_psi_write", PSI_WRITE, 0);
    wait_done(0, 20, ok);
    chk("t1_latency", cyc - t_tr, 3);
    req_valid[0] = 0;
    repeat (2) @(negedge PCLK);
    #1;
    chk("t1_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("t1_slverr", rsp_slverr, 0);
    chk("t1_transfers", tr_cnt - t0c, 1);
    chk("t1_dones", done_cnt - d0, 1);

    // All four requesting, eight transfers from reset
    pulse_reset();
    @(negedge PCLK);
    #1;
    gq.delete(); dq.delete();
    cfg_rdata = 32'h0BAD_F00D;
    for (int i = 0; i < NR; i++) set_req(i, 1, 0, 32'h1000_0000 + 32'(i*16), 0);
    n = 0;
    for (int k = 0; k < 200 && n < 8; k++) begin
      @(negedge PCLK);
      if (|req_done) n++;
    end
    req_valid = '0;
    if (n < 8) chk("timeout_rr", n, 8);
    repeat (2) @(negedge PCLK);
    #1;
    chk("t2_grants", gq.size(), 8);
    chk("t2_dones", dq.size(), 8);
    for (int k = 0; k < 8; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = k % NR;
`endif
      chk($sformatf("t2_grant%0d", k), gq[k], exp_g);
      chk($sformatf("t2_done%0d", k), dq[k], exp_g);
    end

    // Write with three wait states; fields change after issue
    @(negedge PCLK);
    cfg_wait = 3;
    t0c = tr_cnt;
    set_req(2, 1, 1, 32'h8000_0000, 32'h1234_5678);
    wait_tr(20, idx);
    t_tr = cyc;
    chk("t3_grant", idx, 2);
    @(negedge PCLK);
    req_addr[2*AW +: AW]  = 32'h0;
    req_wdata[2*DW +: DW] = 32'hFFFF_0000;
    wait_done(2, 30, ok);
    chk("t3_latency", cyc - t_tr, 6);
    chk("t3_psi_addr", PSI_ADDR, 32'h8000_0000);
    chk("t3_psi_wdata", PSI_WDATA, 32'h1234_5678);
    chk("t3_psi_write", PSI_WRITE, 1);
    req_valid[2] = 0;
    @(negedge PCLK);
    #1;
    chk("t3_rdata_held", rsp_rdata, 32'h0BAD_F00D);
    chk("t3_transfers", tr_cnt - t0c, 1);

    // Errored read, then requester 2 takes the next slot
    @(negedge PCLK);
    cfg_wait = 0; cfg_err = 1; cfg_rdata = 32'hE1E1_E1E1;
    set_req(1, 1, 0, 32'h4000_0100, 32'h0);
    set_req(2, 1, 1, 32'h4000_0200, 32'h5555_AAAA);
    wait_done(1, 20, ok);
    chk("t4_slverr", rsp_slverr, 1);
    chk("t4_rdata", rsp_rdata, 32'hE1E1_E1E1);
    req_valid[1] = 0;
    cfg_err = 0;
    wait_tr(20, idx);
    chk("t4_next_grant", idx, 2);
    wait_done(2, 20, ok);
    chk("t4_slverr_clear", rsp_slverr, 0);
    req_valid[2] = 0;

    // Drop during WAIT, then reset during WAIT
    @(negedge PCLK);
    cfg_wait = 2;
    set_req(3, 1, 0, 32'hC000_0000, 32'h0);
    wait_tr(20, idx);
    chk("t5_grant", idx, 3);
    repeat (2) @(negedge PCLK);
    req_valid[3] = 0;
    wait_done(3, 20, ok);
    chk("t5_done_after_drop", ok, 1);
    @(negedge PCLK);
    cfg_wait = 6;
    set_req(3, 1, 0, 32'hC000_0040, 32'h0);
    wait_tr(20, idx);
    repeat (3) @(negedge PCLK);
    d0 = done_cnt;
    #2 PRESETn = 0;
    #1;
    chk("t5_rst_gnt", req_gnt, 0);
    chk("t5_rst_done", req_done, 0);
    chk("t5_rst_transfer", Transfer, 0);
    chk("t5_rst_psi_addr", PSI_ADDR, 0);
    chk("t5_rst_rdata", rsp_rdata, 0);
    chk("t5_rst_slverr", rsp_slverr, 0);
    for (int i = 0; i < NR; i++) set_req(i, 1, 0, 32'h2000_0000 + 32'(i*4), 0);
    repeat (2) @(negedge PCLK);
    #2 PRESETn = 1;
    wait_tr(20, idx);
    chk("t5_resume_grant", idx, 0);
    chk("t5_no_done_in_reset", done_cnt - d0, 0);

    // Random traffic
    rand_bus = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge PCLK);
      for (int i = 0; i < NR; i++) begin
        if (req_done[i]) begin
          set_req(i, ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                  $urandom, $urandom);
        end else if (req_gnt[i]) begin
          if ($urandom_range(0, 9) == 0) req_valid[i] = 0;
          if ($urandom_range(0, 3) == 0) begin
            req_write[i] = ~req_write[i];
            req_addr[i*AW +: AW]  = $urandom;
            req_wdata[i*DW +: DW] = $urandom;
          end
        end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          set_req(i, 1, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end
      end
    end
    req_valid = '0;
    repeat (20) @(negedge PCLK);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
